// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register address width,
// forwarding-select encodings, muldiv sequencer states and the forwarding rule.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // The younger producer (MEM) wins over WB; $0 is hardwired and never forwarded.
    function automatic fwd_sel_t fwd_select(
        input reg_addr_t src,
        input reg_addr_t mem_rd,
        input logic      mem_we,
        input reg_addr_t wb_rd,
        input logic      wb_we
    );
        fwd_sel_t sel;
        sel = FWD_REGFILE;
        if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave):
// decoded ID fields, EX/MEM/WB destinations in, stall/flush/forward/muldiv controls out.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    reg_addr_t   id_rs;
    reg_addr_t   id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_is_mul;
    logic        id_is_div;
    logic        id_reads_hilo;
    reg_addr_t   ex_rs;
    reg_addr_t   ex_rt;
    reg_addr_t   ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    reg_addr_t   mem_rd;
    logic        mem_reg_write;
    reg_addr_t   wb_rd;
    logic        wb_reg_write;

    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        md_start;
    logic        md_is_div;
    logic        md_busy;
    logic        md_done;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mul, id_is_div, id_reads_hilo,
        output ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
        output mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, fwd_a, fwd_b,
        input  md_start, md_is_div, md_busy, md_done
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mul, id_is_div, id_reads_hilo,
        input  ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
        input  mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, fwd_a, fwd_b,
        output md_start, md_is_div, md_busy, md_done
    );

endinterface

// File: rtl/hazard_ctrl_md_sequencer.sv
// Multi-cycle MULT/DIV occupancy tracker: an op started at cycle N reports
// md_done at cycle N+L-1 and holds md_busy for the cycles in between.
module hazard_ctrl_md_sequencer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             done_reg;
    logic [CNT_W-1:0] load_next;

    assign load_next = is_div ? DIV_LOAD : MUL_LOAD;

    // The counter holds L-1 in the first busy cycle; done is registered at the
    // edge leaving the cycle where it reads 2, so it lands exactly at N+L-1.
    // A 2-cycle op never enters BUSY: done follows the issue edge directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                MD_IDLE: begin
                    if (issue) begin
                        cnt_reg <= load_next;
                        if (load_next == CNT_W'(1)) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(2)) begin
                        done_reg  <= 1'b1;
                        state_reg <= MD_IDLE;
                    end
                end
                default: state_reg <= MD_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == MD_BUSY);
    assign done = done_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS sequencing control: load-use and muldiv stalls, branch flush,
// EX operand forwarding, and issue control of the multi-cycle MULT/DIV unit.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    logic      lu;
    logic      mdh;
    logic      stall;
    logic      md_issue;
    logic      md_busy;
    logic      md_done;
    reg_addr_t ex_src [2];
    fwd_sel_t  fwd    [2];

    assign lu = hz.ex_mem_read && (hz.ex_rd != '0) &&
                ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                 (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

    // md_busy is already low in the md_done cycle, so an MFHI/MFLO or a
    // back-to-back mul/div proceeds there without a special case.
    assign mdh   = md_busy && (hz.id_is_mul || hz.id_is_div || hz.id_reads_hilo);
    assign stall = lu || mdh;

    assign hz.pc_stall     = stall && !hz.ex_branch_taken;
    assign hz.if_id_stall  = stall && !hz.ex_branch_taken;
    assign hz.id_ex_bubble = stall || hz.ex_branch_taken;
    assign hz.if_id_flush  = hz.ex_branch_taken;

    assign ex_src[0] = hz.ex_rs;
    assign ex_src[1] = hz.ex_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] = fwd_select(ex_src[gi], hz.mem_rd, hz.mem_reg_write,
                                        hz.wb_rd, hz.wb_reg_write);
        end
    endgenerate

    assign hz.fwd_a = fwd[0];
    assign hz.fwd_b = fwd[1];

    assign md_issue     = (hz.id_is_mul || hz.id_is_div) && !stall && !hz.ex_branch_taken;
    assign hz.md_start  = md_issue;
    assign hz.md_is_div = hz.id_is_div;

    hazard_ctrl_md_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_sequencer (
        .clk    (clk),
        .rst    (rst),
        .issue  (md_issue),
        .is_div (hz.id_is_div),
        .busy   (md_busy),
        .done   (md_done)
    );

    assign hz.md_busy = md_busy;
    assign hz.md_done = md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: directed scenarios then random traffic,
// expected outputs from a cycle-indexed reference model of the hazard rules.
module tb_hazard_ctrl;

    localparam int MUL_L = 4;
    localparam int DIV_L = 32;

    logic clk;
    logic rst;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MUL_CYCLES (MUL_L),
        .DIV_CYCLES (DIV_L),
        .CNT_W      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] v;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: at most one muldiv op in flight, described by
    // the cycle it started and its latency.
    bit   have_op    = 0;
    int   iss_cyc    = 0;
    int   op_lat     = 0;
    int   cyc        = 0;
    bit   last_stall = 0;
    bit   last_issue = 0;

    function automatic logic [1:0] fwd_ref(input logic [4:0] src);
        if (hz.mem_reg_write && hz.mem_rd != 0 && hz.mem_rd == src) return 2'b10;
        if (hz.wb_reg_write && hz.wb_rd != 0 && hz.wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_cycle(output logic [11:0] v);
        bit busy, done, lu, mdh, stall, issue, tk;
        busy  = have_op && (cyc > iss_cyc) && (cyc < iss_cyc + op_lat - 1);
        done  = have_op && (cyc == iss_cyc + op_lat - 1);
        tk    = hz.ex_branch_taken;
        lu    = hz.ex_mem_read && hz.ex_rd != 0 &&
                ((hz.id_uses_rs && hz.id_rs == hz.ex_rd) || (hz.id_uses_rt && hz.id_rt == hz.ex_rd));
        mdh   = busy && (hz.id_is_mul || hz.id_is_div || hz.id_reads_hilo);
        stall = lu || mdh;
        issue = (hz.id_is_mul || hz.id_is_div) && !stall && !tk;
        v = {stall && !tk, stall && !tk, stall || tk, tk,
             fwd_ref(hz.ex_rs), fwd_ref(hz.ex_rt),
             issue, hz.id_is_div, busy, done};
        if (issue) begin
            have_op = 1;
            iss_cyc = cyc;
            op_lat  = hz.id_is_div ? DIV_L : MUL_L;
        end
        if (rst) have_op = 0;
        last_stall = stall && !tk;
        last_issue = issue;
        cyc++;
    endtask

    task automatic step();
        exp_t e;
        logic [11:0] v;
        e.cyc = cyc;
        model_cycle(v);
        e.v = v;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
        hz.id_is_mul = 0; hz.id_is_div = 0; hz.id_reads_hilo = 0;
        hz.ex_rs = 0; hz.ex_rt = 0; hz.ex_rd = 0; hz.ex_reg_write = 0;
        hz.ex_mem_read = 0; hz.ex_branch_taken = 0;
        hz.mem_rd = 0; hz.mem_reg_write = 0; hz.wb_rd = 0; hz.wb_reg_write = 0;
    endtask

    // Monitor: outputs are combinational/registered every cycle, so one
    // expectation is consumed per cycle at the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            logic [11:0] got;
            e = sb_q.pop_front();
            got = {hz.pc_stall, hz.if_id_stall, hz.id_ex_bubble, hz.if_id_flush,
                   hz.fwd_a, hz.fwd_b, hz.md_start, hz.md_is_div, hz.md_busy, hz.md_done};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL outputs cyc=%0d got=%b exp=%b (ps,ifs,bub,fl,fa,fb,st,dv,by,dn)",
                         e.cyc, got, e.v);
            end else begin
                $display("ok cyc=%0d out=%b", e.cyc, got);
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();

        // load-use, then the same with $0 as destination
        hz.ex_mem_read = 1; hz.ex_rd = 5; hz.id_rs = 5; hz.id_uses_rs = 1;
        step();
        hz.ex_rd = 0;
        step();
        clear_inputs();

        // forwarding priority
        hz.ex_rs = 8; hz.ex_rt = 8; hz.mem_rd = 8; hz.wb_rd = 8;
        hz.mem_reg_write = 1; hz.wb_reg_write = 1;
        step();
        hz.mem_reg_write = 0;
        step();
        hz.ex_rs = 0;
        step();
        clear_inputs();

        // MULT, then MFHI held in ID until it may issue
        hz.id_is_mul = 1;
        step();
        hz.id_is_mul = 0;
        hz.id_reads_hilo = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!last_stall) break;
        end
        hz.id_reads_hilo = 0;
        step();

        // DIV followed by a MULT held in ID
        hz.id_is_div = 1;
        step();
        hz.id_is_div = 0;
        hz.id_is_mul = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (last_issue) break;
        end
        hz.id_is_mul = 0;
        repeat (5) step();

        // flush beats load-use and blocks a mul issue
        hz.ex_branch_taken = 1; hz.ex_mem_read = 1; hz.ex_rd = 3;
        hz.id_rt = 3; hz.id_uses_rt = 1; hz.id_is_mul = 1;
        step();
        clear_inputs();
        step();

        // reset in the middle of a DIV
        hz.id_is_div = 1;
        step();
        hz.id_is_div = 0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (35) step();
        hz.id_is_mul = 1;
        step();
        hz.id_is_mul = 0;
        repeat (5) step();

        // random traffic; a stalled ID instruction usually stays in ID
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (!(last_stall && $urandom_range(3) != 0)) begin
                hz.id_rs = 5'($urandom_range(7));
                hz.id_rt = 5'($urandom_range(7));
                hz.id_uses_rs = 1'($urandom_range(1));
                hz.id_uses_rt = 1'($urandom_range(1));
                r = int'($urandom_range(15));
                hz.id_is_mul = (r == 0);
                hz.id_is_div = (r == 1);
                hz.id_reads_hilo = (r == 2 || r == 3);
            end
            hz.ex_rs = 5'($urandom_range(7));
            hz.ex_rt = 5'($urandom_range(7));
            hz.ex_rd = 5'($urandom_range(7));
            hz.ex_reg_write = 1'($urandom_range(1));
            hz.ex_mem_read = ($urandom_range(2) == 0);
            hz.ex_branch_taken = ($urandom_range(15) == 0);
            hz.mem_rd = 5'($urandom_range(7));
            hz.mem_reg_write = 1'($urandom_range(1));
            hz.wb_rd = 5'($urandom_range(7));
            hz.wb_reg_write = 1'($urandom_range(1));
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;
        clear_inputs();

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
